// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one shared full-adder cell (two half adders + OR),
// LSB first, one bit per clock, with valid/ready operand and result handshakes.

module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high. Operands are taken only in IDLE; the result is held in DONE until taken.
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;

  logic s1, c1, s_bit, c2, carry_next;

  half_adder u_ha1 (.x(a_sr_q[0]), .y(b_sr_q[0]), .s(s1),    .c(c1));
  half_adder u_ha2 (.x(s1),        .y(carry_q),   .s(s_bit), .c(c2));
  assign carry_next = c1 | c2;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        carry_d = carry_next;
        acc_d   = {s_bit, acc_q[WIDTH-1:1]};
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        if (cnt_q == LAST_BIT) begin
          // Counter holds at the last index rather than wrapping.
          sum_d   = {s_bit, acc_q[WIDTH-1:1]};
          cout_d  = carry_next;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Sequencer that performs WIDTH-bit addition bit-serially, LSB first, one bit per clock.
- Uses a single shared one-bit full-adder cell built from two half_adder instances plus an OR, and owns the carry flip-flop.
- Intended for area-constrained datapaths where a parallel adder is too costly.
- Operands are accepted and results returned over valid/ready handshakes.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH), width of the internal bit-index counter. Derived; not to be overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand set a/b/cin is valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in
- out_valid  output  1  result sum/cout valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  registered result a+b+cin, modulo 2^WIDTH
- cout  output  1  registered carry-out of the addition
- busy  output  1  high in RUN or DONE

Behaviour:
- Clock and reset
  - One clock domain.
  - rst asserted at any time forces: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, bit counter=0, carry FF=0, operand shift registers=0.
  - Reset mid-operation abandons that operation; no result is produced.
- States: IDLE, RUN, DONE.
- IDLE
  - in_ready=1.
  - On an edge with in_valid=1:
    - load a and b into shift registers
    - load carry FF with cin
    - clear the sum shift register
    - set counter=0
    - go to RUN
  - in_valid=0: stay in IDLE.
- RUN
  - in_ready=0, busy=1.
  - Each edge processes bit counter using the LSBs of the operand shift registers:
    - s1=a0^b0, c1=a0&b0 (half adder 1)
    - s=s1^carry, c2=s1&carry (half adder 2)
    - carry<=c1|c2
    - s shifts into the sum register MSB; operand registers shift right
    - counter increments
  - On the edge where counter==WIDTH-1:
    - the final bit is processed
    - sum output register <= assembled sum, including that bit
    - cout <= the final carry
    - go to DONE
- DONE
  - out_valid=1, busy=1, in_ready=0.
  - sum and cout are stable while out_valid=1 and out_ready=0.
  - On an edge with out_ready=1: out_valid drops and state returns to IDLE.
  - New operands cannot be accepted on the same edge; the earliest next accept is the following edge.
- Latency: out_valid rises exactly WIDTH clock edges after the accept edge.
- Throughput: at most one operation per WIDTH+2 cycles with out_ready held high.
- Handshake rules
  - in_valid while in_ready=0 is ignored; a, b and cin are not sampled.
  - a, b and cin are sampled only on the accept edge; later changes do not affect the result.
  - out_ready while out_valid=0 has no effect.
- Output values outside DONE
  - sum and cout keep the last completed result (0 after reset) until the next completion.
  - They are never updated mid-RUN.
- Arithmetic: {cout,sum} == a+b+cin computed at WIDTH+1 bits, exact for all operands including all-ones+all-ones+1.
- Counter: no wrap in RUN; the DONE transition occurs at WIDTH-1.

Test Plan:
- Reset behaviour: assert rst for 3 cycles, release -> in_ready=1, out_valid=0, busy=0, sum=0x00, cout=0.
- Carry propagation with WIDTH=8: a=0xFF, b=0x01, cin=0 accepted at edge N -> out_valid=1 first seen after edge N+8, sum=0x00, cout=1.
- Backpressure and ignored input:
  - a=0x5A, b=0x3C, cin=1 accepted; out_ready held 0 for 5 cycles in DONE -> out_valid held 1, sum=0x97, cout=0 stable every cycle.
  - in_valid=1 with a=0x11 during that time -> ignored.
  - out_ready=1 -> IDLE on the next edge.
- Reset mid-operation: accept a=0xAA, b=0x55, assert rst after 3 RUN edges -> immediate IDLE, out_valid never asserts, sum=0x00.
  - Next accept of a=0x01, b=0x02, cin=0 -> sum=0x03, cout=0.
- Extremes with WIDTH=8:
  - a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
  - a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
- Random regression: 1000 random operand sets with random in_valid/out_ready gaps, at WIDTH=8 and WIDTH=13, checked against a reference a+b+cin.
  - Every result is checked.
  - Latency is exactly WIDTH edges from accept.
  - No result is lost or duplicated.
